// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding word fetch at a time and
// buffers returned instructions in a 2-entry FIFO presented to the decoder.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT      = 2'd1;
  localparam logic [1:0] ST_WAIT_DROP = 2'd2;
  localparam int         DEPTH        = 2;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;

  // Each entry is {instruction, pc}; entry 0 is the head.
  logic [63:0] ent_q [DEPTH];
  logic [63:0] ent_d [DEPTH];

  logic        req_fire;
  logic        push;
  logic        pop;
  logic        head_shown;
  logic [1:0]  wr_idx;
  logic [63:0] push_ent;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h3;

  assign head_shown     = (count_q != 2'd0) && !rst;
  assign imem_req_valid = (state_q == ST_IDLE) && (count_q < 2'(DEPTH))
                          && !redirect_valid && !rst;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = head_shown && !redirect_valid;
  assign instruction    = head_shown ? ent_q[0][63:32] : 32'h0;
  assign instr_pc       = head_shown ? ent_q[0][31:0]  : 32'h0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = instr_valid && instr_ready;
  assign push     = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
  assign push_ent = {imem_resp_data, req_pc_q};

  // A same-cycle pop shifts the entries down first, so the write slot moves with it.
  assign wr_idx = count_q - {1'b0, pop};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [63:0] shift_src;
    if (gi < DEPTH - 1) begin : g_mid
      assign shift_src = ent_q[gi+1];
    end else begin : g_last
      assign shift_src = ent_q[gi];
    end
    assign ent_d[gi] = (push && (wr_idx == 2'(gi))) ? push_ent :
                       (pop ? shift_src : ent_q[gi]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_resp_valid ? ST_IDLE : ST_WAIT_DROP;
        end else if (imem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DROP: begin
        if (imem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (req_fire) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 32'd4;
    end
    if (redirect_valid) pc_d = redirect_aligned;
  end

  always_comb begin
    count_d = count_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC_ALIGNED;
      req_pc_q <= RESET_PC_ALIGNED;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run, all
// checked against a stream model (fetch/deliver PC sequences) and a memory model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NONE   = 32'hDEAD_DEAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Staged stimulus, applied just after the next rising edge.
  logic        g_rst = 1'b1;
  logic        g_ready = 1'b0;
  logic        g_rdr = 1'b0;
  logic [31:0] g_rdr_pc = 32'h0;
  logic        rand_mode = 1'b0;
  logic        scramble = 1'b0;
  int          fixed_lat = 0;

  // Memory model: one outstanding request, answered after a latency.
  logic        mem_busy = 1'b0;
  int          mem_lat = 0;
  logic [31:0] mem_addr = 32'h0;

  // Reference stream: next address to be fetched, next PC to be delivered.
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] exp_deliver = RST_PC;

  int          cyc = 0;
  int          hs_total = 0;
  logic        s_reqv, s_iv, s_acc, s_hs;
  logic [31:0] s_addr, s_instr, s_ipc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return scramble ? ({a[15:0], a[31:16]} ^ 32'h5A5A_A5A5) : a;
  endfunction

  task automatic run_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      g_ready  = ($urandom_range(0, 9) < 7);
      g_rdr    = ($urandom_range(0, 15) == 0);
      g_rdr_pc = $urandom;
      imem_req_ready = ($urandom_range(0, 3) != 0);
    end else begin
      imem_req_ready = 1'b1;
    end
    rst             = g_rst;
    instr_ready     = g_ready;
    redirect_valid  = g_rdr;
    redirect_pc     = g_rdr_pc;
    g_rdr           = 1'b0;
    imem_resp_valid = mem_busy && (mem_lat == 0);
    imem_resp_data  = mem_func(mem_addr);
    #1;
    s_reqv  = imem_req_valid;
    s_addr  = imem_req_addr;
    s_iv    = instr_valid;
    s_instr = instruction;
    s_ipc   = instr_pc;
    s_acc   = imem_req_valid && imem_req_ready;
    s_hs    = instr_valid && instr_ready;
    if (rst) begin
      chk("rst_reqv", 32'(s_reqv), 0);
      chk("rst_ivalid", 32'(s_iv), 0);
      mem_busy    = 1'b0;
      exp_fetch   = RST_PC;
      exp_deliver = RST_PC;
    end else begin
      if (redirect_valid) begin
        chk("rdr_reqv", 32'(s_reqv), 0);
        chk("rdr_ivalid", 32'(s_iv), 0);
      end else if (!s_iv) begin
        chk("empty_instr", s_instr, 0);
        chk("empty_pc", s_ipc, 0);
      end
      if (s_acc) begin
        chk("one_outstanding", 32'(mem_busy), 0);
        chk("req_addr", s_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (s_hs) begin
        $display("deliver cyc=%0d pc=%h instr=%h", cyc, s_ipc, s_instr);
        chk("hs_pc", s_ipc, exp_deliver);
        chk("hs_data", s_instr, mem_func(s_ipc));
        exp_deliver = exp_deliver + 32'd4;
        hs_total++;
      end
      if (redirect_valid) begin
        exp_fetch   = redirect_pc & ~32'h3;
        exp_deliver = redirect_pc & ~32'h3;
      end
      if (imem_resp_valid) mem_busy = 1'b0;
      else if (mem_busy && mem_lat != 0) mem_lat--;
      if (s_acc) begin
        mem_busy = 1'b1;
        mem_addr = s_addr;
        mem_lat  = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
      end
    end
  endtask

  task automatic do_reset();
    g_rst = 1'b1;
    run_cycle();
    run_cycle();
    chk("reset_reqv", 32'(s_reqv), 0);
    chk("reset_ivalid", 32'(s_iv), 0);
    chk("reset_instr", s_instr, 0);
    chk("reset_ipc", s_ipc, 0);
    chk("reset_addr", s_addr, RST_PC);
    g_rst = 1'b0;
  endtask

  logic [31:0] hpc [3];
  int          hcyc [3];
  logic [31:0] aa [2];

  initial begin
    int n, na, base, nacc, fa_cyc;
    logic [31:0] fa, fh;

    // Free-run from reset: one instruction every 2 cycles, data == address.
    do_reset();
    g_ready = 1'b1; fixed_lat = 0;
    run_cycle();
    chk("first_reqv", 32'(s_reqv), 1);
    chk("first_addr", s_addr, RST_PC);
    base = cyc; n = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      if (s_hs && n < 3) begin hpc[n] = s_ipc; hcyc[n] = cyc - base; n++; end
    end
    chk("t1_count", n, 3);
    chk("t1_pc0", hpc[0], 32'h100);
    chk("t1_pc1", hpc[1], 32'h104);
    chk("t1_pc2", hpc[2], 32'h108);
    chk("t1_latency", hcyc[0], 2);
    chk("t1_gap1", hcyc[1] - hcyc[0], 2);
    chk("t1_gap2", hcyc[2] - hcyc[1], 2);

    // Backpressure: two responses fill the buffer, then fetching stops.
    do_reset();
    g_ready = 1'b0; nacc = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      if (s_acc) nacc++;
    end
    chk("t2_accepts", nacc, 2);
    chk("t2_reqv_full", 32'(s_reqv), 0);
    chk("t2_ivalid", 32'(s_iv), 1);
    chk("t2_head", s_ipc, 32'h100);
    g_ready = 1'b1; n = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (s_hs && n < 2) begin hpc[n] = s_ipc; n++; end
    end
    chk("t2_count", n, 2);
    chk("t2_pc0", hpc[0], 32'h100);
    chk("t2_pc1", hpc[1], 32'h104);

    // Redirect while the 0x104 fetch is in flight; its late response is dropped.
    do_reset();
    g_ready = 1'b1; fixed_lat = 0;
    run_cycle();
    fixed_lat = 3;
    run_cycle();
    run_cycle();
    chk("t3_acc104", s_acc ? s_addr : NONE, 32'h104);
    fixed_lat = 0;
    g_rdr = 1'b1; g_rdr_pc = 32'h203;
    run_cycle();
    base = cyc; fa = NONE; fh = NONE; fa_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      if (s_acc && fa == NONE) begin fa = s_addr; fa_cyc = cyc - base; end
      if (s_hs && fh == NONE) fh = s_ipc;
    end
    chk("t3_first_req", fa, 32'h200);
    chk("t3_req_delay", fa_cyc, 4);
    chk("t3_first_pc", fh, 32'h200);

    // Redirect in the same cycle as the response.
    do_reset();
    g_ready = 1'b1; fixed_lat = 1;
    run_cycle();
    fixed_lat = 0;
    run_cycle();
    g_rdr = 1'b1; g_rdr_pc = 32'h300;
    run_cycle();
    run_cycle();
    chk("t4_reqv", 32'(s_reqv), 1);
    chk("t4_addr", s_addr, 32'h300);
    chk("t4_ivalid", 32'(s_iv), 0);
    fh = NONE;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (s_hs && fh == NONE) fh = s_ipc;
    end
    chk("t4_first_pc", fh, 32'h300);

    // Redirect with a full buffer and the decoder ready.
    do_reset();
    g_ready = 1'b0; fixed_lat = 0;
    for (int i = 0; i < 6; i++) run_cycle();
    chk("t5_full_iv", 32'(s_iv), 1);
    chk("t5_full_reqv", 32'(s_reqv), 0);
    g_ready = 1'b1; g_rdr = 1'b1; g_rdr_pc = 32'h400;
    run_cycle();
    chk("t5_rdr_hs", 32'(s_hs), 0);
    run_cycle();
    chk("t5_flush_iv", 32'(s_iv), 0);
    chk("t5_flush_instr", s_instr, 0);
    chk("t5_flush_pc", s_ipc, 0);
    chk("t5_new_addr", s_reqv ? s_addr : NONE, 32'h400);

    // PC wrap, with an unaligned redirect target.
    g_rdr = 1'b1; g_rdr_pc = 32'hFFFF_FFFF;
    run_cycle();
    na = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      if (s_acc && na < 2) begin aa[na] = s_addr; na++; end
      if (s_hs && n < 2) begin hpc[n] = s_ipc; n++; end
    end
    chk("t6_nacc", na, 2);
    chk("t6_addr0", aa[0], 32'hFFFF_FFFC);
    chk("t6_addr1", aa[1], 32'h0000_0000);
    chk("t6_pc0", hpc[0], 32'hFFFF_FFFC);
    chk("t6_pc1", hpc[1], 32'h0000_0000);

    // Reset in WAIT with a buffered entry.
    do_reset();
    g_ready = 1'b0; fixed_lat = 0;
    run_cycle();
    fixed_lat = 5;
    run_cycle();
    run_cycle();
    run_cycle();
    chk("t7_wait_iv", 32'(s_iv), 1);
    chk("t7_wait_reqv", 32'(s_reqv), 0);
    fixed_lat = 0;
    do_reset();
    run_cycle();
    chk("t7_restart", s_reqv ? s_addr : NONE, RST_PC);

    // Randomized traffic: backpressure, variable latency, random redirects.
    do_reset();
    scramble = 1'b1; fixed_lat = -1; hs_total = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) run_cycle();
    rand_mode = 1'b0;
    chk("rand_progress", 32'(hs_total > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
